// File: rtl/ball_motion_controller.sv
// Ball velocity/position owner: latches per-frame collision pulses, applies bat-angle
// and reflection rules, wall bounces, serve from the bat and the ball-lost countdown.
module ball_motion_controller #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 16,
  parameter int TOP_WALL    = 32,
  parameter int BAT_Y       = 440,
  parameter int LOST_FRAMES = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic [4:0]        ballCollision,
  input  logic [2:0]        batCollision,
  input  logic [10:0]       batCenterX,
  input  logic              launchReq,
  input  logic              pause,
  output logic [10:0]       ballTopLeftX,
  output logic [10:0]       ballTopLeftY,
  output logic signed [3:0] speedX,
  output logic signed [3:0] speedY,
  output logic              ballLost,
  output logic              ballActive
);

  localparam int CW = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
  localparam logic signed [11:0] HALF = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] XMAX = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] YTOP = 12'(TOP_WALL);
  localparam logic signed [11:0] YBOT = 12'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, MOVING, LOST} state_t;

  state_t            state, state_n;
  logic [3:0]        flags_q, flags_n, flags_eff;
  logic [2:0]        bat_q, bat_n, bat_eff;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [10:0]       x_n, y_n, track_x;
  logic signed [3:0] sx_n, sy_n, sx_u, sy_u;
  logic signed [11:0] track, nx, ny;
  logic              lost_n;

  function automatic logic signed [3:0] abs4(input logic signed [3:0] v);
    return v[3] ? -v : v;
  endfunction

  assign ballActive = (state == MOVING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ballTopLeftX <= batCenterX - 11'(BALL_SIZE / 2);
      ballTopLeftY <= 11'(BAT_Y - BALL_SIZE);
      speedX       <= '0;
      speedY       <= '0;
      ballLost     <= 1'b0;
      flags_q      <= '0;
      bat_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state        <= state_n;
      ballTopLeftX <= x_n;
      ballTopLeftY <= y_n;
      speedX       <= sx_n;
      speedY       <= sy_n;
      ballLost     <= lost_n;
      flags_q      <= flags_n;
      bat_q        <= bat_n;
      cnt_q        <= cnt_n;
    end
  end

  always_comb begin
    // A pulse coinciding with startOfFrame is folded into this frame's update
    flags_eff = flags_q | (ballCollision[4] ? ballCollision[3:0] : 4'b0);
    bat_eff   = (ballCollision[4] && batCollision != '0) ? batCollision : bat_q;

    track = $signed({1'b0, batCenterX}) - HALF;
    if (track < 12'sd0)     track_x = '0;
    else if (track > XMAX)  track_x = 11'(SCREEN_W - BALL_SIZE);
    else                    track_x = track[10:0];

    sx_u = speedX;
    sy_u = speedY;
    if (bat_eff != '0) begin
      case (bat_eff)
        3'd1:    begin sx_u = -4'sd6; sy_u = -4'sd3; end
        3'd2:    begin sx_u = -4'sd4; sy_u = -4'sd4; end
        3'd3:    begin sx_u = -4'sd2; sy_u = -4'sd6; end
        3'd4:    begin sx_u =  4'sd0; sy_u = -4'sd7; end
        3'd5:    begin sx_u =  4'sd2; sy_u = -4'sd6; end
        3'd6:    begin sx_u =  4'sd4; sy_u = -4'sd4; end
        default: begin sx_u =  4'sd6; sy_u = -4'sd3; end
      endcase
    end else begin
      case (flags_eff[3:2])
        2'b10:   sx_u = abs4(speedX);
        2'b01:   sx_u = -abs4(speedX);
        2'b11:   sx_u = -speedX;
        default: sx_u = speedX;
      endcase
      case (flags_eff[1:0])
        2'b10:   sy_u = -abs4(speedY);
        2'b01:   sy_u = abs4(speedY);
        2'b11:   sy_u = -speedY;
        default: sy_u = speedY;
      endcase
    end

    nx = $signed({1'b0, ballTopLeftX}) + $signed({{8{sx_u[3]}}, sx_u});
    ny = $signed({1'b0, ballTopLeftY}) + $signed({{8{sy_u[3]}}, sy_u});

    state_n = state;
    x_n     = ballTopLeftX;
    y_n     = ballTopLeftY;
    sx_n    = speedX;
    sy_n    = speedY;
    lost_n  = 1'b0;
    cnt_n   = cnt_q;
    flags_n = flags_eff;
    bat_n   = bat_eff;

    if (startOfFrame) begin
      flags_n = '0;
      bat_n   = '0;
      if (!pause) begin
        case (state)
          IDLE: begin
            x_n  = track_x;
            y_n  = 11'(BAT_Y - BALL_SIZE);
            sx_n = '0;
            sy_n = '0;
            if (launchReq) begin
              state_n = MOVING;
              sx_n    = 4'sd4;
              sy_n    = -4'sd4;
            end
          end
          MOVING: begin
            if (ny >= YBOT) begin
              state_n = LOST;
              lost_n  = 1'b1;
              sx_n    = '0;
              sy_n    = '0;
              cnt_n   = '0;
            end else begin
              // Wall results override collision-derived speed on the same axis
              if (nx <= 12'sd0) begin
                x_n  = '0;
                sx_n = abs4(sx_u);
              end else if (nx >= XMAX) begin
                x_n  = 11'(SCREEN_W - BALL_SIZE);
                sx_n = -abs4(sx_u);
              end else begin
                x_n  = nx[10:0];
                sx_n = sx_u;
              end
              if (ny <= YTOP) begin
                y_n  = 11'(TOP_WALL);
                sy_n = abs4(sy_u);
              end else begin
                y_n  = ny[10:0];
                sy_n = sy_u;
              end
            end
          end
          default: begin
            if (cnt_q == CW'(LOST_FRAMES - 1)) begin
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_controller.sv
// Self-checking bench for ball_motion_controller: directed scenarios then random frames,
// compared every cycle against a frame-level behavioural model.
module tb_ball_motion_controller;

  logic              clk = 1'b0;
  logic              reset, startOfFrame, launchReq, pause;
  logic [4:0]        ballCollision;
  logic [2:0]        batCollision;
  logic [10:0]       batCenterX;
  logic [10:0]       ballTopLeftX, ballTopLeftY;
  logic signed [3:0] speedX, speedY;
  logic              ballLost, ballActive;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: ball position/velocity as plain integers, phase as flags
  int mx, my, mvx, mvy, mlost_frames, mflags, mbat;
  bit m_moving, m_in_lost, m_pulse;
  int tab_vx[8] = '{0, -6, -4, -2, 0, 2, 4, 6};
  int tab_vy[8] = '{0, -3, -4, -6, -7, -6, -4, -3};
  bit seen_lost;

  ball_motion_controller #(
    .SCREEN_W(640), .SCREEN_H(480), .BALL_SIZE(16),
    .TOP_WALL(32), .BAT_Y(440), .LOST_FRAMES(60)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .ballCollision(ballCollision), .batCollision(batCollision),
    .batCenterX(batCenterX), .launchReq(launchReq), .pause(pause),
    .ballTopLeftX(ballTopLeftX), .ballTopLeftY(ballTopLeftY),
    .speedX(speedX), .speedY(speedY), .ballLost(ballLost), .ballActive(ballActive)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int fl, bt, nx, ny, t;
    fl = mflags | (ballCollision[4] ? int'(ballCollision[3:0]) : 0);
    bt = (ballCollision[4] && batCollision != 0) ? int'(batCollision) : mbat;
    m_pulse = 0;
    if (reset) begin
      m_moving = 0; m_in_lost = 0; mlost_frames = 0;
      mx = (int'(batCenterX) - 8) & 'h7FF; my = 424;
      mvx = 0; mvy = 0; mflags = 0; mbat = 0;
      return;
    end
    if (!startOfFrame) begin
      mflags = fl; mbat = bt;
      return;
    end
    mflags = 0; mbat = 0;
    if (pause) return;
    if (m_moving) begin
      if (bt != 0) begin
        mvx = tab_vx[bt]; mvy = tab_vy[bt];
      end else begin
        if ((fl & 12) == 12)     mvx = -mvx;
        else if ((fl & 8) != 0)  mvx = iabs(mvx);
        else if ((fl & 4) != 0)  mvx = -iabs(mvx);
        if ((fl & 3) == 3)       mvy = -mvy;
        else if ((fl & 2) != 0)  mvy = -iabs(mvy);
        else if ((fl & 1) != 0)  mvy = iabs(mvy);
      end
      nx = mx + mvx; ny = my + mvy;
      if (ny >= 480) begin
        m_moving = 0; m_in_lost = 1; m_pulse = 1; mlost_frames = 0;
        mvx = 0; mvy = 0;
      end else begin
        if (nx <= 0)        begin mx = 0;   mvx = iabs(mvx);  end
        else if (nx >= 624) begin mx = 624; mvx = -iabs(mvx); end
        else                mx = nx;
        if (ny <= 32) begin my = 32; mvy = iabs(mvy); end
        else          my = ny;
      end
    end else if (m_in_lost) begin
      mlost_frames++;
      if (mlost_frames == 60) begin
        m_in_lost = 0; mlost_frames = 0;
      end
    end else begin
      t = int'(batCenterX) - 8;
      mx = (t < 0) ? 0 : (t > 624) ? 624 : t;
      my = 424; mvx = 0; mvy = 0;
      if (launchReq) begin
        m_moving = 1; mvx = 4; mvy = -4;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (ballLost) seen_lost = 1;
    chk("x", int'(ballTopLeftX), mx);
    chk("y", int'(ballTopLeftY), my);
    chk("speedX", int'(speedX), mvx);
    chk("speedY", int'(speedY), mvy);
    chk("ballLost", int'(ballLost), int'(m_pulse));
    chk("ballActive", int'(ballActive), int'(m_moving));
  endtask

  task automatic cyc(input logic sof, input logic [4:0] bc, input logic [2:0] bat);
    startOfFrame = sof; ballCollision = bc; batCollision = bat;
    tick();
    startOfFrame = 1'b0; ballCollision = '0; batCollision = '0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'b0, 3'b0);
  endtask

  task automatic frame();
    quiet(2);
    cyc(1'b1, 5'b0, 3'b0);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; ballCollision = '0; batCollision = '0;
    batCenterX = 11'd300; launchReq = 1'b0; pause = 1'b0; seen_lost = 0;
    tick(); tick();
    chk("rst_x", int'(ballTopLeftX), 292);
    chk("rst_y", int'(ballTopLeftY), 424);
    chk("rst_active", int'(ballActive), 0);
    reset = 1'b0;

    // Serve, then first move
    quiet(2);
    launchReq = 1'b1; cyc(1'b1, 5'b0, 3'b0); launchReq = 1'b0;
    chk("launch_vx", int'(speedX), 4);
    chk("launch_vy", int'(speedY), -4);
    frame();
    chk("move1_x", int'(ballTopLeftX), 296);
    chk("move1_y", int'(ballTopLeftY), 420);

    // Bat code beats flags
    quiet(1); cyc(1'b0, 5'b10010, 3'b101); quiet(1); cyc(1'b1, 5'b0, 3'b0);
    chk("bat5_vx", int'(speedX), 2);
    chk("bat5_vy", int'(speedY), -6);
    chk("bat5_x", int'(ballTopLeftX), 298);
    chk("bat5_y", int'(ballTopLeftY), 414);
    quiet(1); cyc(1'b0, 5'b10000, 3'b110); cyc(1'b1, 5'b0, 3'b0);
    quiet(1); cyc(1'b0, 5'b10001, 3'b000); cyc(1'b1, 5'b0, 3'b0);
    chk("top_hit_vy", int'(speedY), 4);

    // Pulse on the startOfFrame cycle, then bottom hit, then latch cleared
    quiet(2); cyc(1'b1, 5'b10001, 3'b000);
    chk("sof_pulse_vy", int'(speedY), 4);
    quiet(1); cyc(1'b0, 5'b10010, 3'b000); cyc(1'b1, 5'b0, 3'b0);
    chk("bottom_vy", int'(speedY), -4);
    frame();
    chk("latch_clear_vy", int'(speedY), -4);

    // Free flight: side wall, top wall, then out the bottom
    for (int f = 0; f < 400 && !seen_lost; f++) frame();
    chk("lost_seen", int'(seen_lost), 1);
    quiet(1);

    // LOST countdown with a paused frame that must not count
    for (int f = 0; f < 30; f++) frame();
    pause = 1'b1; frame(); pause = 1'b0;
    for (int f = 0; f < 29; f++) frame();
    chk("lost_hold_active", int'(ballActive), 0);
    launchReq = 1'b1; frame(); launchReq = 1'b0;
    chk("lost_exit_vx", int'(speedX), 0);
    batCenterX = 11'd5; frame();
    chk("clamp_lo_x", int'(ballTopLeftX), 0);
    batCenterX = 11'd635; frame();
    chk("clamp_hi_x", int'(ballTopLeftX), 624);

    // Reset during LOST
    batCenterX = 11'd300;
    launchReq = 1'b1; frame(); launchReq = 1'b0;
    quiet(1); cyc(1'b0, 5'b10001, 3'b000);
    seen_lost = 0;
    for (int f = 0; f < 40 && !seen_lost; f++) frame();
    chk("lost2_seen", int'(seen_lost), 1);
    for (int f = 0; f < 5; f++) frame();
    reset = 1'b1; cyc(1'b0, 5'b10011, 3'b111); reset = 1'b0;
    chk("rst_lost_x", int'(ballTopLeftX), 292);
    for (int f = 0; f < 3; f++) frame();

    // Random frames
    for (int f = 0; f < 400; f++) begin
      batCenterX = 11'($urandom_range(0, 700));
      pause      = ($urandom_range(0, 7) == 0);
      launchReq  = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
        if ($urandom_range(0, 2) == 0)
          cyc(1'b0, {1'b1, 4'($urandom)}, 3'($urandom));
        else
          cyc(1'b0, {1'b0, 4'($urandom)}, 3'($urandom));
      end
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0)
        cyc(1'b1, {1'b1, 4'($urandom)}, 3'($urandom));
      else
        cyc(1'b1, 5'b0, 3'b0);
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
